// File: rtl/reg_file_ptr.sv
// reg_file_ptr: pointer-addressed register file with zeroing sweep; define REG_FILE_BYPASS_EN for write-to-read bypass
module reg_file_ptr #(
  parameter int DATA_W = 8,
  parameter int NUM_REGS = 16,
  parameter int MOV_REG = 7,
  localparam int IDX_W = $clog2(NUM_REGS)
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              REGWRITE,
  input  logic              SETSRC,
  input  logic              SETDEST,
  input  logic              MOV,
  input  logic              AUTOINC,
  input  logic              CLEAR,
  input  logic [IDX_W-1:0]  rt_index,
  input  logic [DATA_W-1:0] write_value,
  output logic [DATA_W-1:0] rs,
  output logic [DATA_W-1:0] rt,
  output logic [IDX_W-1:0]  src_ptr,
  output logic [IDX_W-1:0]  dest_ptr,
  output logic              BUSY,
  output logic              ERR
);
  typedef enum logic {IDLE, SWEEP} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [IDX_W-1:0] cnt, wr_idx;
  logic [3:0] cmd;
  logic idle, ok, legal, wr_en;
  assign cmd = {REGWRITE, SETSRC, SETDEST, MOV};
  assign idle = state == IDLE;
  assign ok = idle && !CLEAR;
  assign legal = cmd[3:1] == 3'b100 || cmd == 4'b0100 || cmd == 4'b0010;
  assign wr_en = ok && cmd[3:1] == 3'b100;
  assign wr_idx = MOV ? IDX_W'(MOV_REG) : dest_ptr;
  assign BUSY = !idle;
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = idle ? (CLEAR ? SWEEP : IDLE) : (cnt == IDX_W'(NUM_REGS - 1) ? IDLE : SWEEP);
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      src_ptr <= '0;
      dest_ptr <= '0;
      cnt <= '0;
      ERR <= 1'b0;
    end else begin
      if (|cmd && !(ok && legal)) ERR <= 1'b1;
      if (wr_en) regs[wr_idx] <= write_value;
      if (ok && cmd == 4'b0100) src_ptr <= rt_index;
      if (ok && cmd == 4'b0010) dest_ptr <= rt_index;
      if (ok && cmd == 4'b1000 && AUTOINC) dest_ptr <= dest_ptr + 1'b1;
      if (!idle) regs[cnt] <= '0;
      cnt <= idle ? '0 : cnt + 1'b1;
    end
`ifdef REG_FILE_BYPASS_EN
  assign rs = wr_en && wr_idx == src_ptr ? write_value : regs[src_ptr];
  assign rt = wr_en && wr_idx == rt_index ? write_value : regs[rt_index];
`else
  assign rs = regs[src_ptr];
  assign rt = regs[rt_index];
`endif
endmodule

// File: tb/tb_reg_file_ptr.sv
// tb_reg_file_ptr: directed self-checking bench for reg_file_ptr (default build)
module tb_reg_file_ptr;
  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  logic REGWRITE, SETSRC, SETDEST, MOV, AUTOINC, CLEAR;
  logic [3:0] rt_index, src_ptr, dest_ptr;
  logic [7:0] write_value, rs, rt;
  logic BUSY, ERR;
  int checks = 0;
  int failures = 0;
  int busy_cnt;
  reg_file_ptr dut (
    .CLK(CLK), .RESET_N(RESET_N), .REGWRITE(REGWRITE), .SETSRC(SETSRC), .SETDEST(SETDEST),
    .MOV(MOV), .AUTOINC(AUTOINC), .CLEAR(CLEAR), .rt_index(rt_index), .write_value(write_value),
    .rs(rs), .rt(rt), .src_ptr(src_ptr), .dest_ptr(dest_ptr), .BUSY(BUSY), .ERR(ERR)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [5:0] c, input logic [3:0] i, input logic [7:0] v);
    {REGWRITE, SETSRC, SETDEST, MOV, AUTOINC, CLEAR} = c;
    rt_index = i;
    write_value = v;
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic op(input logic [5:0] c, input logic [3:0] i, input logic [7:0] v);
    drive(c, i, v);
    tick();
    drive(6'b000000, i, 8'h00);
  endtask
  task automatic rd(input logic [3:0] i);
    rt_index = i;
    #1;
  endtask
  initial begin
    drive(6'b000000, 4'd0, 8'h00);
    #12;
    chk("rst_busy", BUSY, 0);
    chk("rst_err", ERR, 0);
    chk("rst_src", src_ptr, 0);
    chk("rst_dest", dest_ptr, 0);
    chk("rst_rs", rs, 0);
    RESET_N = 1'b1;
    tick();
    op(6'b001000, 4'd3, 8'h00);
    chk("setdest3", dest_ptr, 3);
    op(6'b100000, 4'd3, 8'hA5);
    op(6'b010000, 4'd3, 8'h00);
    chk("setsrc3", src_ptr, 3);
    chk("rs_a5", rs, 8'hA5);
    chk("rt_a5", rt, 8'hA5);
    chk("err0_a", ERR, 0);
    op(6'b001000, 4'd15, 8'h00);
    op(6'b100010, 4'd0, 8'h11);
    op(6'b100010, 4'd0, 8'h22);
    chk("autoinc_dest", dest_ptr, 1);
    rd(4'd15);
    chk("reg15", rt, 8'h11);
    rd(4'd0);
    chk("reg0", rt, 8'h22);
    op(6'b010000, 4'd4, 8'h00);
    op(6'b001000, 4'd4, 8'h00);
    drive(6'b100000, 4'd4, 8'h5A);
    #1;
    chk("rs_old", rs, 8'h00);
    tick();
    drive(6'b000000, 4'd4, 8'h00);
    chk("rs_new", rs, 8'h5A);
    chk("no_ai_dest", dest_ptr, 4);
    op(6'b000010, 4'd0, 8'h00);
    chk("ai_alone_dest", dest_ptr, 4);
    op(6'b001010, 4'd2, 8'h00);
    chk("ai_setdest", dest_ptr, 2);
    chk("err0_b", ERR, 0);
    op(6'b100100, 4'd0, 8'h3C);
    rd(4'd7);
    chk("mov_reg7", rt, 8'h3C);
    rd(4'd2);
    chk("mov_reg2", rt, 8'h00);
    chk("mov_dest", dest_ptr, 2);
    chk("err0_c", ERR, 0);
    op(6'b110000, 4'd9, 8'h77);
    chk("bad_src", src_ptr, 4);
    chk("bad_dest", dest_ptr, 2);
    rd(4'd2);
    chk("bad_reg2", rt, 8'h00);
    chk("bad_err", ERR, 1);
    #1 RESET_N = 1'b0;
    #1;
    chk("rst2_err", ERR, 0);
    chk("rst2_src", src_ptr, 0);
    chk("rst2_dest", dest_ptr, 0);
    rd(4'd3);
    chk("rst2_reg3", rt, 8'h00);
    #1 RESET_N = 1'b1;
    tick();
    op(6'b001000, 4'd0, 8'h00);
    for (int i = 0; i < 16; i++) op(6'b100010, 4'd0, 8'hFF);
    chk("fill_dest_wrap", dest_ptr, 0);
    op(6'b010000, 4'd9, 8'h00);
    op(6'b001000, 4'd2, 8'h00);
    rd(4'd5);
    chk("fill_reg5", rt, 8'hFF);
    chk("fill_rs9", rs, 8'hFF);
    chk("fill_err", ERR, 0);
    chk("fill_busy", BUSY, 0);
    op(6'b000001, 4'd0, 8'h00);
    busy_cnt = 0;
    for (int i = 0; i < 40 && BUSY; i++) begin
      busy_cnt++;
      if (busy_cnt == 6) op(6'b100000, 4'd2, 8'h99);
      else tick();
    end
    chk("sweep_len", busy_cnt, 16);
    chk("sweep_done", BUSY, 0);
    chk("sweep_err", ERR, 1);
    chk("sweep_src", src_ptr, 9);
    chk("sweep_dest", dest_ptr, 2);
    for (int i = 0; i < 16; i++) begin
      rd(4'(i));
      chk($sformatf("swept_reg%0d", i), rt, 8'h00);
      tick();
    end
    #1 RESET_N = 1'b0;
    #1 RESET_N = 1'b1;
    tick();
    chk("rst3_err", ERR, 0);
    op(6'b001000, 4'd12, 8'h00);
    op(6'b100000, 4'd12, 8'h44);
    op(6'b010000, 4'd9, 8'h00);
    rd(4'd12);
    chk("pre_reg12", rt, 8'h44);
    op(6'b010001, 4'd5, 8'h00);
    chk("clrcmd_busy", BUSY, 1);
    chk("clrcmd_src", src_ptr, 9);
    chk("clrcmd_err", ERR, 1);
    repeat (8) tick();
    chk("mid_busy", BUSY, 1);
    #2 RESET_N = 1'b0;
    #1;
    chk("abort_busy", BUSY, 0);
    chk("abort_err", ERR, 0);
    chk("abort_src", src_ptr, 0);
    chk("abort_dest", dest_ptr, 0);
    rd(4'd12);
    chk("abort_reg12", rt, 8'h00);
    #1 RESET_N = 1'b1;
    tick();
    chk("post_busy", BUSY, 0);
    for (int i = 0; i < 16; i++) begin
      rd(4'(i));
      chk($sformatf("post_reg%0d", i), rt, 8'h00);
      tick();
    end
    chk("post_busy2", BUSY, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
